// File: rtl/audio_frame_sender.sv
// audio_frame_sender: reads NUM_SAMPLES stored samples from a registered-read
// memory and streams them to a byte transmitter as one framed packet:
//   SYNC0, SYNC1, count[15:8], count[7:0], {hi, lo} per sample, checksum.
// The checksum is the mod-256 sum of the count and sample bytes.
//
// Handshakes:
//   req/did_send : 4-phase. The frame starts on req=1 (only once req has been
//                  seen low since the previous frame). did_send stays high
//                  until req falls.
//   tx_req/tx_ack: 4-phase. tx_data is valid while tx_req=1 and is held
//                  until the ack has fallen again. tx_req is never raised
//                  while tx_ack is still high.
module audio_frame_sender #(
    parameter int         ADDR_W      = 11,
    parameter int         DATA_W      = 10,
    parameter int         NUM_SAMPLES = 1024,
    parameter logic [7:0] SYNC0       = 8'hA5,
    parameter logic [7:0] SYNC1       = 8'h5A
) (
    input  logic              clk_100,
    input  logic              rst_n,
    input  logic              req,
    output logic              did_send,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [7:0]        tx_data,
    output logic              tx_req,
    input  logic              tx_ack,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MEM_RD    = 3'd1,
        S_MEM_WAIT  = 3'd2,
        S_SEND_REQ  = 3'd3,
        S_WAIT_ACK1 = 3'd4,
        S_WAIT_ACK0 = 3'd5,
        S_NEXT      = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    // Which byte of the frame is current.
    typedef enum logic [2:0] {
        B_SYNC0  = 3'd0,
        B_SYNC1  = 3'd1,
        B_CNT_HI = 3'd2,
        B_CNT_LO = 3'd3,
        B_SMP_HI = 3'd4,
        B_SMP_LO = 3'd5,
        B_CSUM   = 3'd6
    } sel_t;

    localparam logic [15:0]       SAMPLE_CNT = 16'(NUM_SAMPLES);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_SAMPLES - 1);

    state_t              state_q, state_d;
    sel_t                sel_q, sel_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [7:0]          csum_q, csum_d;
    logic [15:0]         sample_q, sample_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_req_q, tx_req_d;
    logic                busy_q, busy_d;
    logic                did_send_q, did_send_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    // Set once req has been seen low; a new frame needs this set.
    logic                armed_q, armed_d;
    logic [7:0]          cur_byte;

    assign did_send    = did_send_q;
    assign busy        = busy_q;
    assign mem_addr    = mem_addr_q;
    assign tx_data     = tx_data_q;
    assign tx_req      = tx_req_q;
    assign dbg_state_o = state_q;

    // Select the byte value for the current frame position.
    always_comb begin
        cur_byte = 8'h00;
        case (sel_q)
            B_SYNC0:  cur_byte = SYNC0;
            B_SYNC1:  cur_byte = SYNC1;
            B_CNT_HI: cur_byte = SAMPLE_CNT[15:8];
            B_CNT_LO: cur_byte = SAMPLE_CNT[7:0];
            B_SMP_HI: cur_byte = sample_q[15:8];
            B_SMP_LO: cur_byte = sample_q[7:0];
            B_CSUM:   cur_byte = csum_q;
            default:  cur_byte = 8'h00;
        endcase
    end

    // Next-state and output logic of the frame sequencer.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        sample_d   = sample_q;
        tx_data_d  = tx_data_q;
        tx_req_d   = tx_req_q;
        busy_d     = busy_q;
        did_send_d = did_send_q;
        armed_d    = armed_q | ~req;

        case (state_q)
            S_IDLE: begin
                // A transmitter still acking a previous byte defers the start.
                if (req && !tx_ack && armed_q) begin
                    idx_d   = '0;
                    csum_d  = 8'h00;
                    sel_d   = B_SYNC0;
                    busy_d  = 1'b1;
                    armed_d = 1'b0;
                    state_d = S_SEND_REQ;
                end
            end
            S_MEM_RD: begin
                state_d = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                // Read data is valid this cycle (one cycle after the address).
                sample_d = 16'(mem_data);
                state_d  = S_SEND_REQ;
            end
            S_SEND_REQ: begin
                tx_data_d = cur_byte;
                tx_req_d  = 1'b1;
                if (sel_q != B_SYNC0 && sel_q != B_SYNC1 && sel_q != B_CSUM) begin
                    csum_d = csum_q + cur_byte;
                end
                state_d = S_WAIT_ACK1;
            end
            S_WAIT_ACK1: begin
                if (tx_ack) begin
                    tx_req_d = 1'b0;
                    state_d  = S_WAIT_ACK0;
                end
            end
            S_WAIT_ACK0: begin
                if (!tx_ack) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                case (sel_q)
                    B_SYNC0: begin
                        sel_d   = B_SYNC1;
                        state_d = S_SEND_REQ;
                    end
                    B_SYNC1: begin
                        sel_d   = B_CNT_HI;
                        state_d = S_SEND_REQ;
                    end
                    B_CNT_HI: begin
                        sel_d   = B_CNT_LO;
                        state_d = S_SEND_REQ;
                    end
                    B_CNT_LO: begin
                        sel_d   = B_SMP_HI;
                        state_d = S_MEM_RD;
                    end
                    B_SMP_HI: begin
                        sel_d   = B_SMP_LO;
                        state_d = S_SEND_REQ;
                    end
                    B_SMP_LO: begin
                        // idx stops at the last sample so it never wraps.
                        if (idx_q != LAST_IDX) begin
                            idx_d   = idx_q + ADDR_W'(1);
                            sel_d   = B_SMP_HI;
                            state_d = S_MEM_RD;
                        end else begin
                            sel_d   = B_CSUM;
                            state_d = S_SEND_REQ;
                        end
                    end
                    B_CSUM: begin
                        did_send_d = 1'b1;
                        state_d    = S_DONE;
                    end
                    default: begin
                        state_d = S_DONE;
                    end
                endcase
            end
            S_DONE: begin
                if (!req) begin
                    did_send_d = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The read address tracks idx for the whole frame, zero otherwise.
        mem_addr_d = busy_d ? idx_d : '0;
    end

    // State and output registers; reset drops everything immediately.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sel_q      <= B_SYNC0;
            idx_q      <= '0;
            csum_q     <= 8'h00;
            sample_q   <= 16'h0000;
            tx_data_q  <= 8'h00;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            did_send_q <= 1'b0;
            mem_addr_q <= '0;
            armed_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            sample_q   <= sample_d;
            tx_data_q  <= tx_data_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
            did_send_q <= did_send_d;
            mem_addr_q <= mem_addr_d;
            armed_q    <= armed_d;
        end
    end

endmodule

// File: tb/tb_audio_frame_sender.sv
// Bench for audio_frame_sender: a 4-sample instance (address space exactly
// full) for frame content, handshake and reset behaviour, and a 1024-sample
// instance for address coverage and the long checksum.
module tb_audio_frame_sender;

    localparam int         NA        = 4;
    localparam int         NB        = 1024;
    localparam logic [7:0] SYNC0     = 8'hA5;
    localparam logic [7:0] SYNC1     = 8'h5A;
    localparam logic [2:0] ST_MEM_RD = 3'd1;

    // ---------------- clock / reset ----------------
    logic clk_100;
    logic rst_n;

    initial begin
        clk_100 = 1'b0;
        forever #5 clk_100 = ~clk_100;
    end

    // ---------------- DUT A (4 samples) ----------------
    logic       a_req, a_did, a_busy, a_txreq, a_ack;
    logic [1:0] a_addr;
    logic [9:0] a_mdata;
    logic [7:0] a_txd;
    logic [2:0] a_state;
    logic [9:0] a_mem [NA];

    audio_frame_sender #(.ADDR_W(2), .DATA_W(10), .NUM_SAMPLES(NA)) dut_a (
        .clk_100(clk_100), .rst_n(rst_n), .req(a_req), .did_send(a_did),
        .busy(a_busy), .mem_addr(a_addr), .mem_data(a_mdata), .tx_data(a_txd),
        .tx_req(a_txreq), .tx_ack(a_ack), .dbg_state_o(a_state)
    );

    always @(posedge clk_100) a_mdata <= a_mem[a_addr];

    // ---------------- DUT B (1024 samples, mem[i]=i) ----------------
    logic        b_req, b_did, b_busy, b_txreq, b_ack;
    logic [10:0] b_addr;
    logic [9:0]  b_mdata;
    logic [7:0]  b_txd;
    logic [2:0]  b_state;

    audio_frame_sender #(.ADDR_W(11), .DATA_W(10), .NUM_SAMPLES(NB)) dut_b (
        .clk_100(clk_100), .rst_n(rst_n), .req(b_req), .did_send(b_did),
        .busy(b_busy), .mem_addr(b_addr), .mem_data(b_mdata), .tx_data(b_txd),
        .tx_req(b_txreq), .tx_ack(b_ack), .dbg_state_o(b_state)
    );

    always @(posedge clk_100) b_mdata <= b_addr[9:0];

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [7:0]  exp_a_q[$];
    logic [7:0]  exp_b_q[$];
    logic [10:0] exp_addr_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input bit to_b, input logic [7:0] v);
        if (to_b) exp_b_q.push_back(v);
        else exp_a_q.push_back(v);
    endtask

    // Model of one full frame from the memory contents.
    task automatic push_frame(input bit to_b);
        int          n;
        logic [15:0] cnt;
        logic [15:0] s;
        logic [7:0]  cs;
        n   = to_b ? NB : NA;
        cnt = 16'(n);
        cs  = 8'h00;
        push_byte(to_b, SYNC0);
        push_byte(to_b, SYNC1);
        push_byte(to_b, cnt[15:8]);
        push_byte(to_b, cnt[7:0]);
        cs = cs + cnt[15:8] + cnt[7:0];
        for (int i = 0; i < n; i++) begin
            s = to_b ? 16'(i) : 16'(a_mem[i]);
            push_byte(to_b, s[15:8]);
            push_byte(to_b, s[7:0]);
            cs = cs + s[15:8] + s[7:0];
            if (to_b) exp_addr_q.push_back(11'(i));
        end
        push_byte(to_b, cs);
    endtask

    task automatic sb_a(input logic [7:0] v);
        logic [7:0] e;
        check("a_byte_avail", 32'(exp_a_q.size() != 0), 1);
        if (exp_a_q.size() != 0) begin
            e = exp_a_q.pop_front();
            check("a_byte", 32'(v), 32'(e));
        end
    endtask

    task automatic sb_b(input logic [7:0] v);
        logic [7:0] e;
        check("b_byte_avail", 32'(exp_b_q.size() != 0), 1);
        if (exp_b_q.size() != 0) begin
            e = exp_b_q.pop_front();
            check("b_byte", 32'(v), 32'(e));
        end
    endtask

    // ---------------- transmitter model A (configurable delays) ----------------
    int         a_ph = 0;
    int         a_cnt = 0;
    int         a_hold = 0;
    int         a_nbytes = 0;
    int         a_stall_at = -1;
    bit         a_rand = 1'b0;
    bit         a_force = 1'b0;
    logic [7:0] a_cur = 8'h00;

    initial begin : tx_model_a
        a_ack = 1'b0;
        forever begin
            @(negedge clk_100);
            if (!rst_n) begin
                a_ack = 1'b0;
                a_ph  = 0;
            end else if (a_force) begin
                a_ack = 1'b1;
                a_ph  = 0;
            end else begin
                case (a_ph)
                    0: begin
                        if (a_txreq) begin
                            a_cur = a_txd;
                            a_nbytes++;
                            sb_a(a_cur);
                            a_cnt = a_rand ? int'($urandom_range(0, 50)) : 0;
                            a_ph  = 1;
                        end
                    end
                    1: begin
                        check("a_req_held", 32'(a_txreq), 1);
                        check("a_data_stable", 32'(a_txd), 32'(a_cur));
                        if (a_nbytes - 1 != a_stall_at) begin
                            if (a_cnt == 0) begin
                                a_ack  = 1'b1;
                                a_hold = a_rand ? int'($urandom_range(1, 20)) : 1;
                                a_ph   = 2;
                            end else begin
                                a_cnt--;
                            end
                        end
                    end
                    default: begin
                        check("a_no_req_while_ack", 32'(a_txreq), 0);
                        check("a_data_stable_ack", 32'(a_txd), 32'(a_cur));
                        a_hold--;
                        if (a_hold <= 0) begin
                            a_ack = 1'b0;
                            a_ph  = 0;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- transmitter model B (immediate ack) ----------------
    int b_nbytes = 0;

    initial begin : tx_model_b
        b_ack = 1'b0;
        forever begin
            @(negedge clk_100);
            if (!rst_n) begin
                b_ack = 1'b0;
            end else if (b_txreq && !b_ack) begin
                b_nbytes++;
                sb_b(b_txd);
                b_ack = 1'b1;
            end else if (!b_txreq) begin
                b_ack = 1'b0;
            end
        end
    end

    // Every memory read of B is checked against the expected address order.
    initial begin : addr_monitor_b
        logic [10:0] e;
        forever begin
            @(negedge clk_100);
            if (rst_n && b_state == ST_MEM_RD) begin
                check("b_addr_avail", 32'(exp_addr_q.size() != 0), 1);
                if (exp_addr_q.size() != 0) begin
                    e = exp_addr_q.pop_front();
                    check("b_mem_addr", 32'(b_addr), 32'(e));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_a_did(input int budget);
        int n = 0;
        while (a_did !== 1'b1 && n < budget) begin
            @(negedge clk_100);
            n++;
        end
        check("a_did_send_rise", 32'(a_did), 1);
    endtask

    task automatic wait_a_bytes(input int k, input int budget);
        int n = 0;
        while (a_nbytes < k && n < budget) begin
            @(negedge clk_100);
            n++;
        end
        check("a_bytes_reached", 32'(a_nbytes >= k), 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : stim
        int w;
        int n;
        a_mem[0] = 10'h3FF;
        a_mem[1] = 10'h001;
        a_mem[2] = 10'h200;
        a_mem[3] = 10'h155;
        a_req = 1'b0;
        b_req = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_100);

        check("rst_did_send", 32'(a_did), 0);
        check("rst_busy", 32'(a_busy), 0);
        check("rst_tx_req", 32'(a_txreq), 0);
        check("rst_tx_data", 32'(a_txd), 0);
        check("rst_mem_addr", 32'(a_addr), 0);
        check("rst_b_busy", 32'(b_busy), 0);
        check("rst_b_tx_req", 32'(b_txreq), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_100);

        // Basic frame, req held high across completion.
        push_frame(1'b0);
        a_nbytes = 0;
        a_req = 1'b1;
        wait_a_did(400);
        check("t1_bytes", 32'(a_nbytes), 13);
        check("t1_left", 32'(exp_a_q.size()), 0);
        repeat (20) @(negedge clk_100);
        check("t1_did_held", 32'(a_did), 1);
        check("t1_busy_held", 32'(a_busy), 1);
        check("t1_no_tx_in_done", 32'(a_txreq), 0);
        a_req = 1'b0;
        @(negedge clk_100);
        check("t1_did_clear", 32'(a_did), 0);
        check("t1_busy_clear", 32'(a_busy), 0);
        repeat (30) @(negedge clk_100);
        check("t1_no_second_frame", 32'(a_busy), 0);

        // req dropped after the first byte: frame completes, did_send pulses.
        push_frame(1'b0);
        a_nbytes = 0;
        a_req = 1'b1;
        wait_a_bytes(1, 100);
        a_req = 1'b0;
        wait_a_did(400);
        w = 0;
        while (a_did === 1'b1 && w < 10) begin
            w++;
            @(negedge clk_100);
        end
        check("t2_did_width", 32'(w), 1);
        check("t2_busy_clear", 32'(a_busy), 0);
        check("t2_left", 32'(exp_a_q.size()), 0);

        // Random ack delays and hold times.
        a_rand = 1'b1;
        push_frame(1'b0);
        a_nbytes = 0;
        a_req = 1'b1;
        repeat (3) @(negedge clk_100);
        a_req = 1'b0;
        wait_a_did(3000);
        @(negedge clk_100);
        check("t3_bytes", 32'(a_nbytes), 13);
        check("t3_left", 32'(exp_a_q.size()), 0);
        a_rand = 1'b0;
        repeat (5) @(negedge clk_100);

        // Reset while sample 2's hi byte waits for its ack.
        push_frame(1'b0);
        a_nbytes = 0;
        a_stall_at = 8;
        a_req = 1'b1;
        wait_a_bytes(9, 400);
        repeat (3) @(negedge clk_100);
        check("t4_pre_tx_req", 32'(a_txreq), 1);
        check("t4_pre_busy", 32'(a_busy), 1);
        check("t4_pre_addr", 32'(a_addr), 2);
        check("t4_pre_data", 32'(a_txd), 32'h02);
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_tx_req", 32'(a_txreq), 0);
        check("t4_rst_busy", 32'(a_busy), 0);
        check("t4_rst_did", 32'(a_did), 0);
        check("t4_rst_addr", 32'(a_addr), 0);
        check("t4_rst_data", 32'(a_txd), 0);
        a_req = 1'b0;
        a_stall_at = -1;
        exp_a_q.delete();
        repeat (2) @(negedge clk_100);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_100);
        push_frame(1'b0);
        a_nbytes = 0;
        a_req = 1'b1;
        wait_a_did(400);
        a_req = 1'b0;
        @(negedge clk_100);
        check("t4_restart_bytes", 32'(a_nbytes), 13);
        check("t4_left", 32'(exp_a_q.size()), 0);

        // Start gated while the transmitter still holds ack high.
        a_force = 1'b1;
        repeat (2) @(negedge clk_100);
        push_frame(1'b0);
        a_nbytes = 0;
        a_req = 1'b1;
        repeat (20) @(negedge clk_100);
        check("t5_no_tx_req", 32'(a_txreq), 0);
        check("t5_not_busy", 32'(a_busy), 0);
        check("t5_no_bytes", 32'(a_nbytes), 0);
        a_force = 1'b0;
        a_ack = 1'b0;
        wait_a_did(400);
        a_req = 1'b0;
        @(negedge clk_100);
        check("t5_bytes", 32'(a_nbytes), 13);
        check("t5_left", 32'(exp_a_q.size()), 0);
        check("t5_busy_clear", 32'(a_busy), 0);

        // Long frame: address coverage and checksum over 1024 samples.
        push_frame(1'b1);
        b_nbytes = 0;
        b_req = 1'b1;
        n = 0;
        while (b_did !== 1'b1 && n < 40000) begin
            @(negedge clk_100);
            n++;
        end
        check("t6_did_send_rise", 32'(b_did), 1);
        check("t6_bytes", 32'(b_nbytes), 2053);
        check("t6_bytes_left", 32'(exp_b_q.size()), 0);
        check("t6_addr_left", 32'(exp_addr_q.size()), 0);
        check("t6_last_addr", 32'(b_addr), 1023);
        b_req = 1'b0;
        @(negedge clk_100);
        check("t6_busy_clear", 32'(b_busy), 0);
        check("t6_addr_idle", 32'(b_addr), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
